// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues in-order fetches at the current PC, buffers the returned
// words with their PCs and hands them to decode; a flush drops queued and in-flight fetches.
module if_fetch_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] pc_in,
   output logic        pc_enable,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntDepth = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);

   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      pc_d    [DEPTH];
   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      instr_d [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] fill_q, fill_d;

   logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic fire;
   logic pop;
   logic rsp_take;

   // Handshake outputs; imem_req is gated by Reset so it drops the moment reset asserts.
   always_comb begin
      imem_req  = Reset && !flush && (alloc_cnt_q < CntDepth);
      imem_addr = pc_in;
      fire      = imem_req && imem_ready;
      pc_enable = fire;
      id_valid  = !flush && filled_q[head_q] && (alloc_cnt_q != '0);
      id_instr  = instr_q[head_q];
      id_pc     = pc_q[head_q];
      pop       = id_valid && id_ready;
      rsp_take  = imem_rsp_valid && (inflight_q != '0);
   end

   always_comb begin
      pc_d        = pc_q;
      instr_d     = instr_q;
      filled_d    = filled_q;
      head_d      = head_q;
      tail_d      = tail_q;
      fill_d      = fill_q;
      alloc_cnt_d = alloc_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      inflight_d  = inflight_q;

      // fire is already forced low during flush, so this holds in both paths.
      if (fire && !rsp_take) begin
         inflight_d = inflight_q + CntOne;
      end else if (!fire && rsp_take) begin
         inflight_d = inflight_q - CntOne;
      end

      if (flush) begin
         head_d      = '0;
         tail_d      = '0;
         fill_d      = '0;
         alloc_cnt_d = '0;
         filled_d    = '0;
         // Everything still outstanding after this edge belongs to the discarded stream.
         drop_cnt_d  = rsp_take ? (inflight_q - CntOne) : inflight_q;
      end else begin
         if (rsp_take) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CntOne;
            end else begin
               instr_d[fill_q]  = imem_rsp_data;
               filled_d[fill_q] = 1'b1;
               fill_d           = fill_q + PtrOne;
            end
         end

         if (fire) begin
            pc_d[tail_q]     = pc_in;
            filled_d[tail_q] = 1'b0;
            tail_d           = tail_q + PtrOne;
         end

         if (pop) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + PtrOne;
         end

         if (fire && !pop) begin
            alloc_cnt_d = alloc_cnt_q + CntOne;
         end else if (!fire && pop) begin
            alloc_cnt_d = alloc_cnt_q - CntOne;
         end
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
         filled_q    <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         fill_q      <= '0;
         alloc_cnt_q <= '0;
         inflight_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= pc_d[i];
            instr_q[i] <= instr_d[i];
         end
         filled_q    <= filled_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         fill_q      <= fill_d;
         alloc_cnt_q <= alloc_cnt_d;
         inflight_q  <= inflight_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues in-order requests to instruction memory (valid/ready, variable response latency), and buffers returned instructions with their PCs in an in-order queue.
- Presents the buffered instructions to decode through a valid/ready handshake.
- Drives the PC register's Enable so the PC advances only when a fetch is accepted. Supports a flush that discards queued and in-flight fetches on a branch/jump redirect.

Parameters:
DEPTH, 4, queue entries and max outstanding fetches; power of two, >= 2
CNT_W, log2(DEPTH)+1, width of occupancy/inflight/drop counters (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
Reset  input  1  asynchronous active-low reset (0 = reset)
pc_in  input  32  current PC from PC register
pc_enable  output  1  Enable to PC register; 1 exactly when a fetch is accepted this cycle
flush  input  1  redirect; discard all queued and in-flight fetches
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= pc_in)
imem_ready  input  1  memory accepts request
imem_rsp_valid  input  1  instruction word returned, in request order
imem_rsp_data  input  32  returned instruction
id_valid  output  1  instruction available to decode
id_instr  output  32  instruction at queue head
id_pc  output  32  PC of instruction at queue head
id_ready  input  1  decode accepts head entry

Behaviour:
- Reset (async, Reset=0):
  - head/tail/fill pointers = 0; alloc_cnt, inflight, drop_cnt = 0; all filled flags = 0.
  - imem_req, pc_enable, id_valid = 0. id_instr and id_pc = 0.
  - Reset mid-operation abandons everything. Responses arriving afterwards with inflight = 0 are ignored.
- Queue: DEPTH entries {pc, instr, filled}. An entry is allocated at issue (tail) and filled at response (fill pointer, in order). It is freed at pop (head). alloc_cnt counts allocated entries.
- Issue:
  - imem_req = !flush && alloc_cnt < DEPTH, using registered alloc_cnt only. A pop in the same cycle does not enable issue.
  - imem_addr = pc_in. fire = imem_req && imem_ready.
  - On fire: entry[tail].pc <= pc_in, filled <= 0; tail++ (wraps mod DEPTH); alloc_cnt++; inflight++.
  - pc_enable = fire, combinational. The PC is held on every non-fire cycle, including full, flush and memory-busy.
- Response (imem_rsp_valid = 1):
  - If inflight = 0: ignore.
  - Else inflight--. If drop_cnt > 0: drop_cnt--, data discarded. Else entry[fill].instr <= imem_rsp_data, filled <= 1, fill++ (wraps).
  - Issue and response in the same cycle: inflight net unchanged.
- Deliver:
  - id_valid = !flush && entry[head].filled && alloc_cnt > 0.
  - id_instr and id_pc come from entry[head], registered state. Minimum latency is fire at T, response at T+k, id_valid at T+k+1.
  - Pop on id_valid && id_ready: filled[head] <= 0, head++, alloc_cnt--.
  - Issue and pop in the same cycle: alloc_cnt net unchanged.
- Flush (flush = 1 at a posedge):
  - No issue and no pop that cycle.
  - head/tail/fill <= 0; alloc_cnt <= 0; all filled <= 0.
  - drop_cnt <= inflight minus (1 if a response arrives this cycle and inflight > 0). This cycle's response is itself discarded.
  - inflight is updated normally.
  - Consecutive flush cycles are legal and idempotent.
  - The PC redirect is handled outside this block; the new PC is fetched on the first cycle after flush deasserts.
- Invariants: inflight <= alloc_cnt + drop_cnt; drop_cnt <= inflight; alloc_cnt <= DEPTH.

Test Plan:
- Reset=0 then 1, imem_ready=1, 1-cycle response latency, id_ready=1, pc_in stepping 0x3000, 0x3004, ... → imem_req=1 from the first cycle; pc_enable pulses every cycle; id_pc sequence 0x3000, 0x3004, ... with matching id_instr, one per cycle after 2-cycle latency.
- id_ready=0, DEPTH=4, four fetches returned → alloc_cnt=4, imem_req=0, pc_enable=0, PC held at 0x3010; one pop → imem_req=1 the next cycle, not the pop cycle.
- imem_ready toggling 1,0,1,0 → pc_enable equals imem_ready each cycle; no duplicate or skipped id_pc values.
- 3 fetches in flight (0x3000–0x3008), flush for 1 cycle coinciding with the 0x3000 response → drop_cnt=2; the next 2 responses are discarded; after redirect to pc_in=0x4000, the first delivered id_pc=0x4000.
- Assert Reset=0 mid-stream with 2 entries filled and 1 in flight → id_valid=0 and imem_req=0 immediately (async); a stray response after release is ignored and the next delivered id_pc equals the first post-reset pc_in.
